// File: rtl/iic_eeprom_ctrl.sv
// iic_eeprom_ctrl: single-master I2C sequencer for a 24Cxx-class EEPROM with
// 8-bit word address. Runs one byte-write or random-read per command.
// Every SCL bit slot is four quarters (L L H H). A quarter tick selects the
// pin levels for the quarter that starts at the next clock edge.
module iic_eeprom_ctrl #(
  parameter int         CLK_DIV = 4,
  parameter logic [2:0] DEV_SEL = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_req,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       cmd_ack,
  output logic [7:0] rd_data,
  output logic       nack_err,
  output logic       busy,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       scl,
  output logic       sdo,
  input  logic       sdi,
  output logic       wp
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QRELOAD = QW'(CLK_DIV - 1);
  localparam logic [QW-1:0] QONE    = QW'(1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_TX      = 4'd2;
  localparam logic [3:0] S_ACK     = 4'd3;
  localparam logic [3:0] S_RESTART = 4'd4;
  localparam logic [3:0] S_RX      = 4'd5;
  localparam logic [3:0] S_MNACK   = 4'd6;
  localparam logic [3:0] S_STOP    = 4'd7;
  localparam logic [3:0] S_ENDW    = 4'd8;  // waits out the last STOP quarter
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic [7:0] CTRL_W = {4'b1010, DEV_SEL, 1'b0};
  localparam logic [7:0] CTRL_R = {4'b1010, DEV_SEL, 1'b1};

  logic [3:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;      // quarter to be emitted at the next tick
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    phase_q, phase_d;  // 0: ctrl W, 1: word addr, 2: wdata / ctrl R
  logic          rw_q, rw_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    shift_q, shift_d;
  logic          abort_q, abort_d;
  logic          scl_q, scl_d;
  logic          sdo_q, sdo_d;
  logic          wp_q, wp_d;
  logic          busy_q, busy_d;
  logic          cmd_ack_q, cmd_ack_d;
  logic          nack_q, nack_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          tick;

  // Quarter timer plus the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    abort_d   = abort_q;
    scl_d     = scl_q;
    sdo_d     = sdo_q;
    wp_d      = wp_q;
    busy_d    = busy_q;
    cmd_ack_d = 1'b0;
    nack_d    = nack_q;
    rd_data_d = rd_data_q;
    tick      = 1'b0;

    // Counter sits at 0 while idle, so the first quarter starts right after acceptance.
    if (state_q == S_IDLE || state_q == S_DONE) begin
      qcnt_d = '0;
    end else begin
      tick   = (qcnt_q == '0);
      qcnt_d = tick ? QRELOAD : (qcnt_q - QONE);
    end
    if (tick) qtr_d = qtr_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_req) begin
          rw_d    = cmd_rw;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          busy_d  = 1'b1;
          wp_d    = cmd_rw;
          abort_d = 1'b0;
          phase_d = 2'd0;
          bit_d   = 3'd0;
          qtr_d   = 2'd0;
          state_d = S_START;
        end
      end
      S_START: if (tick) begin
        // SCL stays high for the whole slot; SDA falls halfway through.
        scl_d = 1'b1;
        sdo_d = ~qtr_q[1];
        if (qtr_q == 2'd3) begin
          shift_d = CTRL_W;
          state_d = S_TX;
        end
      end
      S_TX: if (tick) begin
        scl_d = qtr_q[1];
        if (qtr_q == 2'd0) sdo_d = shift_q[7];
        if (qtr_q == 2'd3) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: if (tick) begin
        scl_d = qtr_q[1];
        if (qtr_q == 2'd0) sdo_d = 1'b1;
        // This tick is the last clock of the high-going quarter: sample ACK now.
        if (qtr_q == 2'd3) begin
          if (sdi) begin
            abort_d = 1'b1;
            state_d = S_STOP;
          end else begin
            case (phase_q)
              2'd0: begin
                phase_d = 2'd1;
                shift_d = addr_q;
                state_d = S_TX;
              end
              2'd1: begin
                phase_d = 2'd2;
                if (rw_q) begin
                  state_d = S_RESTART;
                end else begin
                  shift_d = wdata_q;
                  state_d = S_TX;
                end
              end
              default: state_d = rw_q ? S_RX : S_STOP;
            endcase
          end
        end
      end
      S_RESTART: if (tick) begin
        // SDA is released while SCL is low, then pulled low while SCL is high.
        scl_d = qtr_q[1];
        sdo_d = (qtr_q != 2'd3);
        if (qtr_q == 2'd3) begin
          shift_d = CTRL_R;
          state_d = S_TX;
        end
      end
      S_RX: if (tick) begin
        scl_d = qtr_q[1];
        if (qtr_q == 2'd0) sdo_d = 1'b1;
        if (qtr_q == 2'd3) begin
          shift_d = {shift_q[6:0], sdi};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_MNACK;
        end
      end
      S_MNACK: if (tick) begin
        // Master leaves SDA released on the 9th clock: NACK ends the read.
        scl_d = qtr_q[1];
        if (qtr_q == 2'd0) sdo_d = 1'b1;
        if (qtr_q == 2'd3) state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        scl_d = qtr_q[1];
        sdo_d = (qtr_q == 2'd3);
        if (qtr_q == 2'd3) state_d = S_ENDW;
      end
      S_ENDW: if (tick) begin
        cmd_ack_d = 1'b1;
        nack_d    = abort_q;
        if (rw_q && !abort_q) rd_data_d = shift_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        wp_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      phase_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shift_q   <= '0;
      abort_q   <= 1'b0;
      scl_q     <= 1'b1;
      sdo_q     <= 1'b1;
      wp_q      <= 1'b1;
      busy_q    <= 1'b0;
      cmd_ack_q <= 1'b0;
      nack_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      abort_q   <= abort_d;
      scl_q     <= scl_d;
      sdo_q     <= sdo_d;
      wp_q      <= wp_d;
      busy_q    <= busy_d;
      cmd_ack_q <= cmd_ack_d;
      nack_q    <= nack_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign cmd_ack  = cmd_ack_q;
  assign rd_data  = rd_data_q;
  assign nack_err = nack_q;
  assign busy     = busy_q;
  assign scl      = scl_q;
  assign sdo      = sdo_q;
  assign wp       = wp_q;
  assign a0       = DEV_SEL[0];
  assign a1       = DEV_SEL[1];
  assign a2       = DEV_SEL[2];

endmodule

// File: tb/tb_iic_eeprom_ctrl.sv
// Testbench for iic_eeprom_ctrl: open-drain EEPROM slave model, I2C event
// decoder checked against an expected-event queue, and SCL phase monitor.
module tb_iic_eeprom_ctrl;

  localparam int         CLK_DIV  = 2;
  localparam logic [2:0] DEV_SEL  = 3'b101;
  localparam int         EV_START = 32'h1000;
  localparam int         EV_STOP  = 32'h2000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_req = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ack, nack_err, busy, a0, a1, a2, scl, sdo, sdi, wp;
  logic [7:0] rd_data;

  logic       slave_sda = 1'b1;
  logic       nack_ctrl = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int exp_q[$];

  assign sdi = sdo & slave_sda;

  iic_eeprom_ctrl #(.CLK_DIV(CLK_DIV), .DEV_SEL(DEV_SEL)) dut (
    .clk(clk), .reset(reset), .cmd_req(cmd_req), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack),
    .rd_data(rd_data), .nack_err(nack_err), .busy(busy),
    .a0(a0), .a1(a1), .a2(a2), .scl(scl), .sdo(sdo), .sdi(sdi), .wp(wp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (cmd_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  // Bus decoder, slave model and protocol monitor, sampled on the falling clock edge.
  initial begin
    logic pscl, pline, line, rdm, tog_ok;
    int dbit, dbyte, sh, ev, e, last_tog;
    pscl = 1'b1; pline = 1'b1; rdm = 1'b0; tog_ok = 1'b0;
    dbit = 0; dbyte = 0; sh = 0; ev = 0; e = 0; last_tog = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dbit = 0; dbyte = 0; rdm = 1'b0; tog_ok = 1'b0;
        slave_sda = 1'b1;
        pscl = scl; pline = sdo & slave_sda;
      end else begin
        line = sdo & slave_sda;
        total++;
        if (busy === 1'b0 && wp !== 1'b1) begin
          bad++;
          $display("FAIL wp_idle: wp=%b busy=%b required wp=1 when idle", wp, busy);
        end
        if (scl !== pscl) begin
          if (tog_ok) begin
            total++;
            if (cyc - last_tog != 2 * CLK_DIV) begin
              bad++;
              $display("FAIL scl_phase: length=%0d required=%0d at cyc %0d", cyc - last_tog, 2 * CLK_DIV, cyc);
            end
          end
          tog_ok = 1'b1;
          last_tog = cyc;
        end
        if (busy === 1'b0 && scl === 1'b1) tog_ok = 1'b0;
        ev = -1;
        if (pscl && scl && line !== pline) begin
          ev = line ? EV_STOP : EV_START;
          dbit = 0;
          if (!line) begin
            dbyte = 0;
            rdm = 1'b0;
          end
        end else if (!pscl && scl) begin
          if (dbit < 8) sh = ((sh << 1) | int'(line)) & 255;
          dbit++;
          if (dbit == 9) begin
            ev = (line ? 256 : 0) + sh;
            if (dbyte == 0 && sh[0] && !line) rdm = 1'b1;
            dbit = 0;
            dbyte++;
          end
        end else if (pscl && !scl) begin
          if (dbit == 8) slave_sda = (rdm && dbyte == 1) ? 1'b1 : ((dbyte == 0) ? nack_ctrl : 1'b0);
          else if (rdm && dbyte == 1) slave_sda = rd_byte[7 - dbit];
          else slave_sda = 1'b1;
        end
        if (ev != -1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL i2c_event: got %h required none at cyc %0d", ev, cyc);
          end else begin
            e = exp_q.pop_front();
            if (ev != e) begin
              bad++;
              $display("FAIL i2c_event: got %h required %h at cyc %0d", ev, e, cyc);
            end
          end
        end
        pscl = scl;
        pline = sdo & slave_sda;
      end
    end
  end

  // Issues one command and waits (bounded) for cmd_ack; lat=-1 on timeout.
  task automatic do_cmd(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                        output int lat, output logic nk, output logic [7:0] rd,
                        output logic acc_busy, output logic acc_wp);
    int t0;
    @(negedge clk);
    cmd_req = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge clk);
    cmd_req = 1'b0;
    t0 = cyc; acc_busy = busy; acc_wp = wp;
    lat = -1; nk = 1'bx; rd = 8'hxx;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_ack === 1'b1) begin
        lat = cyc - t0; nk = nack_err; rd = rd_data;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({scl, sdo, wp, busy, cmd_ack, nack_err} !== 6'b111000) begin
      bad++;
      $display("FAIL reset_pins: scl,sdo,wp,busy,ack,nack=%b required 111000", {scl, sdo, wp, busy, cmd_ack, nack_err});
    end
    total++;
    if (rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rd_data: got %h required 00", rd_data);
    end
    total++;
    if ({a2, a1, a0} !== DEV_SEL) begin
      bad++;
      $display("FAIL dev_sel_pins: got %b required %b", {a2, a1, a0}, DEV_SEL);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_write();
    int lat; logic nk, ab, aw; logic [7:0] rd;
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AA); exp_q.push_back(32'h03C);
    exp_q.push_back(32'h0A5); exp_q.push_back(EV_STOP);
    do_cmd(1'b0, 8'h3C, 8'hA5, lat, nk, rd, ab, aw);
    total++;
    if (lat != 116 * CLK_DIV + 1) begin bad++; $display("FAIL write_latency: got %0d required %0d", lat, 116 * CLK_DIV + 1); end
    total++;
    if (nk !== 1'b0) begin bad++; $display("FAIL write_nack: got %b required 0", nk); end
    total++;
    if ({ab, aw} !== 2'b10) begin bad++; $display("FAIL write_accept: busy,wp=%b required 10", {ab, aw}); end
    repeat (2) @(negedge clk);
    total++;
    if ({busy, wp} !== 2'b01) begin bad++; $display("FAIL write_release: busy,wp=%b required 01", {busy, wp}); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL write_events: %0d left required 0", exp_q.size()); end
    $display("write: addr=3c data=a5 latency=%0d nack=%b", lat, nk);
  endtask

  task automatic test_read();
    int lat; logic nk, ab, aw; logic [7:0] rd;
    rd_byte = 8'h5A; nack_ctrl = 1'b0;
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AA); exp_q.push_back(32'h010);
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AB); exp_q.push_back(32'h15A);
    exp_q.push_back(EV_STOP);
    do_cmd(1'b1, 8'h10, 8'h00, lat, nk, rd, ab, aw);
    total++;
    if (lat != 156 * CLK_DIV + 1) begin bad++; $display("FAIL read_latency: got %0d required %0d", lat, 156 * CLK_DIV + 1); end
    total++;
    if (nk !== 1'b0) begin bad++; $display("FAIL read_nack: got %b required 0", nk); end
    total++;
    if (rd !== 8'h5A) begin bad++; $display("FAIL read_data: got %h required 5a", rd); end
    total++;
    if ({ab, aw} !== 2'b11) begin bad++; $display("FAIL read_accept: busy,wp=%b required 11", {ab, aw}); end
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL read_events: %0d left required 0", exp_q.size()); end
    $display("read: addr=10 data=%h latency=%0d nack=%b", rd, lat, nk);
  endtask

  task automatic test_addr_nack();
    int lat; logic nk, ab, aw; logic [7:0] rd;
    nack_ctrl = 1'b1;
    exp_q.push_back(EV_START); exp_q.push_back(32'h1AA); exp_q.push_back(EV_STOP);
    do_cmd(1'b1, 8'h20, 8'h00, lat, nk, rd, ab, aw);
    total++;
    if (lat != 44 * CLK_DIV + 1) begin bad++; $display("FAIL nack_latency: got %0d required %0d", lat, 44 * CLK_DIV + 1); end
    total++;
    if (nk !== 1'b1) begin bad++; $display("FAIL nack_flag: got %b required 1", nk); end
    total++;
    if (rd !== 8'h5A) begin bad++; $display("FAIL nack_rd_hold: got %h required 5a", rd); end
    nack_ctrl = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL nack_events: %0d left required 0", exp_q.size()); end
    $display("addr_nack: latency=%0d nack=%b rd_data=%h", lat, nk, rd);
  endtask

  task automatic test_back_to_back();
    int t0, lat, base;
    base = ack_cnt;
    rd_byte = 8'hC3;
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AA); exp_q.push_back(32'h044);
    exp_q.push_back(32'h099); exp_q.push_back(EV_STOP);
    @(negedge clk);
    cmd_req = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'h99;
    @(negedge clk);
    t0 = cyc;
    cmd_rw = 1'b1; cmd_addr = 8'h77; cmd_wdata = 8'h00;
    for (int i = 0; i < 2000 && cmd_ack !== 1'b1; i++) @(negedge clk);
    lat = (cmd_ack === 1'b1) ? cyc - t0 : -1;
    total++;
    if (lat != 116 * CLK_DIV + 1) begin bad++; $display("FAIL b2b_latency: got %0d required %0d", lat, 116 * CLK_DIV + 1); end
    total++;
    if (ack_cnt - base != 0) begin bad++; $display("FAIL b2b_early_ack: got %0d acks required 0", ack_cnt - base); end
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AA); exp_q.push_back(32'h077);
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AB); exp_q.push_back(32'h1C3);
    exp_q.push_back(EV_STOP);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_ignore: busy=%b required 0", busy); end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_idle_accept: busy=%b required 1", busy); end
    cmd_req = 1'b0;
    for (int i = 0; i < 2000 && cmd_ack !== 1'b1; i++) @(negedge clk);
    total++;
    if (rd_data !== 8'hC3) begin bad++; $display("FAIL b2b_read_data: got %h required c3", rd_data); end
    repeat (2) @(negedge clk);
    total++;
    if (ack_cnt - base != 2) begin bad++; $display("FAIL b2b_ack_count: got %0d required 2", ack_cnt - base); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_events: %0d left required 0", exp_q.size()); end
    $display("back_to_back: first latency=%0d acks=%0d rd_data=%h", lat, ack_cnt - base, rd_data);
  endtask

  task automatic test_reset_mid();
    int lat, base; logic nk, ab, aw; logic [7:0] rd;
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AA);
    @(negedge clk);
    cmd_req = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h3C; cmd_wdata = 8'hA5;
    @(negedge clk);
    cmd_req = 1'b0;
    repeat ((4 * 10 + 16) * CLK_DIV) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL mid_first_byte: %0d events left required 0", exp_q.size()); end
    base = ack_cnt;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({scl, sdo, wp, busy, cmd_ack} !== 5'b11100) begin
      bad++;
      $display("FAIL mid_reset_pins: scl,sdo,wp,busy,ack=%b required 11100", {scl, sdo, wp, busy, cmd_ack});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (ack_cnt != base) begin bad++; $display("FAIL mid_no_ack: got %0d acks required 0", ack_cnt - base); end
    exp_q.delete();
    exp_q.push_back(EV_START); exp_q.push_back(32'h0AA); exp_q.push_back(32'h05E);
    exp_q.push_back(32'h081); exp_q.push_back(EV_STOP);
    do_cmd(1'b0, 8'h5E, 8'h81, lat, nk, rd, ab, aw);
    total++;
    if (lat != 116 * CLK_DIV + 1 || nk !== 1'b0) begin
      bad++;
      $display("FAIL mid_recover: latency=%0d nack=%b required %0d/0", lat, nk, 116 * CLK_DIV + 1);
    end
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL mid_events: %0d left required 0", exp_q.size()); end
    $display("reset_mid: recovery write latency=%0d nack=%b", lat, nk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
